// File: rtl/knn_pkg.sv
// Shared types and constants for the k-nearest-neighbour pipeline.
// The distance-compute stage and the top-K sorter both use knn_entry_t.
package knn_pkg;

   localparam int K = 8;
   localparam int BIT_WIDTH = 16;
   localparam int DIST_WIDTH = 2 * BIT_WIDTH + 2;
   localparam int ADDR_WIDTH = 16;
   localparam int CNT_WIDTH  = $clog2(K + 1);
   localparam logic [DIST_WIDTH-1:0] DIST_MAX = '1;

   typedef struct packed {
      logic [BIT_WIDTH-1:0]  x;
      logic [BIT_WIDTH-1:0]  y;
      logic [BIT_WIDTH-1:0]  z;
      logic [ADDR_WIDTH-1:0] addr;
      logic                  valid;
      logic [DIST_WIDTH-1:0] distance;
   } knn_entry_t;

   typedef enum logic [1:0] {IDLE, ACCEPT, DONE} sorter_state_t;

   // An unoccupied slot: invalid, farthest possible distance.
   function automatic knn_entry_t empty_entry();
      knn_entry_t e;
      e          = '0;
      e.distance = DIST_MAX;
      return e;
   endfunction

endpackage

// File: rtl/knn_topk_sorter_if.sv
// Candidate stream in, sorted neighbour list out, for the top-K sorter.
interface knn_topk_sorter_if;
   import knn_pkg::*;

   logic                    start;
   logic                    in_valid;
   knn_entry_t              in_entry;
   logic                    in_last;
   logic                    in_ready;
   logic                    out_valid;
   logic                    out_ready;
   knn_entry_t [0:K-1]      out_list;
   logic [CNT_WIDTH-1:0]    out_count;

   modport master (
      output start, in_valid, in_entry, in_last, out_ready,
      input  in_ready, out_valid, out_list, out_count
   );

   modport slave (
      input  start, in_valid, in_entry, in_last, out_ready,
      output in_ready, out_valid, out_list, out_count
   );

endinterface

// File: rtl/knn_topk_slot.sv
// One position of the sorted list: keeps its entry, takes the candidate,
// or takes the entry from the slot above when the list shifts down.
module knn_topk_slot
   import knn_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       clear,
   input  logic       insert,
   input  knn_entry_t cand,
   input  knn_entry_t prev_entry,
   input  logic       prev_flag,
   output knn_entry_t entry,
   output logic       flag
);

   knn_entry_t entry_reg;

   // Candidate belongs at or above this slot unless this slot holds a valid
   // entry no farther than it (ties keep the earlier arrival in front).
   assign flag  = !(entry_reg.valid && (entry_reg.distance <= cand.distance));
   assign entry = entry_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         entry_reg <= empty_entry();
      end else if (clear) begin
         entry_reg <= empty_entry();
      end else if (insert && flag) begin
         entry_reg <= prev_flag ? prev_entry : cand;
      end
   end

endmodule

// File: rtl/knn_topk_sorter.sv
// Keeps the K nearest candidates of one query sorted by squared distance
// and hands the finished list downstream over a valid/ready handshake.
module knn_topk_sorter
   import knn_pkg::*;
(
   input  logic               clock,
   input  logic               reset_n,
   knn_topk_sorter_if.slave   bus
);

   sorter_state_t        state_reg;
   logic                 in_ready_reg;
   logic                 out_valid_reg;
   logic [CNT_WIDTH-1:0] count_reg;

   knn_entry_t slot_entry [K];
   logic       slot_flag  [K];
   knn_entry_t prev_entry [K];
   logic       prev_flag  [K];

   logic accept;
   logic do_clear;
   logic do_insert;

   assign accept    = in_ready_reg & bus.in_valid;
   assign do_clear  = bus.start & ((state_reg == IDLE) | (state_reg == ACCEPT));
   // A start in the same cycle aborts the query, so its candidate is dropped.
   assign do_insert = accept & ~bus.start & bus.in_entry.valid;

   genvar gi;
   generate
      for (gi = 0; gi < K; gi++) begin : g_slot
         if (gi == 0) begin : g_head
            assign prev_entry[gi] = empty_entry();
            assign prev_flag[gi]  = 1'b0;
         end else begin : g_link
            assign prev_entry[gi] = slot_entry[gi-1];
            assign prev_flag[gi]  = slot_flag[gi-1];
         end

         knn_topk_slot u_slot (
            .clock      (clock),
            .reset_n    (reset_n),
            .clear      (do_clear),
            .insert     (do_insert),
            .cand       (bus.in_entry),
            .prev_entry (prev_entry[gi]),
            .prev_flag  (prev_flag[gi]),
            .entry      (slot_entry[gi]),
            .flag       (slot_flag[gi])
         );

         assign bus.out_list[gi] = slot_entry[gi];
      end
   endgenerate

   assign bus.in_ready  = in_ready_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_count = count_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         in_ready_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         count_reg     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  state_reg    <= ACCEPT;
                  in_ready_reg <= 1'b1;
                  count_reg    <= '0;
               end
            end
            ACCEPT: begin
               if (bus.start) begin
                  count_reg <= '0;
               end else begin
                  if (do_insert && (count_reg < CNT_WIDTH'(K)))
                     count_reg <= count_reg + CNT_WIDTH'(1);
                  if (accept && bus.in_last) begin
                     state_reg     <= DONE;
                     in_ready_reg  <= 1'b0;
                     out_valid_reg <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
               end
            end
            default: begin
               state_reg     <= IDLE;
               in_ready_reg  <= 1'b0;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule
